wb_master_port: RTL and testbench

- Command-driven Wishbone classic single-transfer master. It converts one internal read/write command into one bus cycle on the shared bus.
- Sits directly upstream of the 4-master bus arbiter. Its CYC_O drives one bit of the arbiter's CYC_I vector, and it watches the arbiter's 2-bit grant index to know when it owns the bus.
- One instance per bus master (DSP core, host bridge, etc.). It drops CYC after every transfer so the round-robin arbiter can rotate.

---
 rtl/wb_master_port.sv | 145 ++++++++++++++
 tb/tb_wb_master_port.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_port.sv
// Wishbone classic single-transfer master: turns one internal command into one
// bus cycle, waits for the arbiter grant, and drops CYC after every transfer.
module wb_master_port #(
    parameter int MASTER_ID = 0,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            rsp_timeout,
    input  logic [1:0]      GNT_I,
    output logic            CYC_O,
    output logic            STB_O,
    output logic            WE_O,
    output logic [AW-1:0]   ADR_O,
    output logic [DW-1:0]   DAT_O,
    output logic [DW/8-1:0] SEL_O,
    input  logic [DW-1:0]   DAT_I,
    input  logic            ACK_I,
    input  logic            ERR_I
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_GNT = 2'd1;
    localparam logic [1:0] STROBE   = 2'd2;
    localparam logic [1:0] GAP      = 2'd3;

    localparam int             TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int             T_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0]  T_LAST   = T_LAST_I[TW-1:0];
    localparam logic [1:0]     MY_SLOT  = MASTER_ID[1:0];

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [TW-1:0]   r_timer;
    logic            r_cmd_ready;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_dat;
    logic            r_rsp_err;
    logic            r_rsp_timeout;
    logic            r_cyc;
    logic            r_stb;
    logic            r_we;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_dat;
    logic [DW/8-1:0] r_sel;

    logic w_owned;
    logic w_accept;
    logic w_err;
    logic w_ack;
    logic w_timeout;
    logic w_done;

    // Slave responses only count while we own the bus and are strobing; ERR beats ACK.
    assign w_owned   = (GNT_I == MY_SLOT);
    assign w_accept  = r_cmd_ready & cmd_valid;
    assign w_err     = w_owned & r_stb & ERR_I;
    assign w_ack     = w_owned & r_stb & ACK_I & ~ERR_I;
    assign w_timeout = (TIMEOUT > 0) && (r_state == STROBE) && !w_ack && !w_err
                       && (r_timer == T_LAST);
    assign w_done    = (r_state == STROBE) && (w_ack || w_err || w_timeout);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next = WAIT_GNT;
            WAIT_GNT: if (w_owned)  w_next = STROBE;
            STROBE:   if (w_done)   w_next = GAP;
            default:                w_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_dat     <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_we          <= 1'b0;
            r_adr         <= '0;
            r_dat         <= '0;
            r_sel         <= '0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == IDLE);
            r_rsp_valid <= w_done;

            if (w_accept) begin
                r_cyc <= 1'b1;
                r_we  <= cmd_we;
                r_adr <= cmd_adr;
                r_dat <= cmd_dat;
                r_sel <= cmd_sel;
            end

            if (r_state == WAIT_GNT && w_owned) begin
                r_stb   <= 1'b1;
                r_timer <= '0;
            end

            if (r_state == STROBE) begin
                if (r_timer != '1)
                    r_timer <= r_timer + 1'b1;
                if (w_done) begin
                    r_cyc         <= 1'b0;
                    r_stb         <= 1'b0;
                    r_rsp_err     <= w_err | w_timeout;
                    r_rsp_timeout <= w_timeout;
                    if (w_ack && !r_we)
                        r_rsp_dat <= DAT_I;
                end
            end
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_dat     = r_rsp_dat;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign CYC_O       = r_cyc;
    assign STB_O       = r_stb;
    assign WE_O        = r_we;
    assign ADR_O       = r_adr;
    assign DAT_O       = r_dat;
    assign SEL_O       = r_sel;

endmodule

// File: tb/tb_wb_master_port.sv
// Scoreboard bench for wb_master_port (slot 2, TIMEOUT 4): expected responses are
// queued at command acceptance and compared when rsp_valid pulses.
module tb_wb_master_port;

    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam int          MID = 2;
    localparam int          TMO = 4;
    localparam logic [31:0] KEY = 32'h5A5A_5A5A;

    logic          CLK = 1'b0;
    logic          RST;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [3:0]    cmd_sel;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_dat;
    logic [1:0]    GNT_I;
    logic          CYC_O, STB_O, WE_O;
    logic [AW-1:0] ADR_O;
    logic [DW-1:0] DAT_O, DAT_I;
    logic [3:0]    SEL_O;
    logic          ACK_I, ERR_I;

    always #5 CLK = ~CLK;

    wb_master_port #(.MASTER_ID(MID), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .GNT_I(GNT_I),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O),
        .DAT_O(DAT_O), .SEL_O(SEL_O), .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
    );

    typedef struct packed {
        logic        err;
        logic        to;
        logic [31:0] dat;
    } rsp_t;

    rsp_t        sb_q[$];
    rsp_t        nxt_exp;
    logic [31:0] model_dat;
    int          total = 0;
    int          bad   = 0;
    int          cyc_n = 0;
    int          acc_cyc, rsp_cyc, stb_cnt, low_run, last_gap;
    logic        prev_rsp, accepted;
    logic        slv_ack_en, slv_err_en, slv_use_adr;
    int          slv_wait;
    logic [31:0] slv_rdata;

    // One clock: pushes accepted commands, plays the slave, and scores responses.
    task automatic step();
        rsp_t e;
        accepted = cmd_valid && cmd_ready && !RST;
        if (accepted) begin
            sb_q.push_back(nxt_exp);
            acc_cyc = cyc_n;
        end
        @(posedge CLK);
        #1;
        cyc_n++;
        if (STB_O) stb_cnt++;
        else       stb_cnt = 0;
        ACK_I = slv_ack_en && STB_O && (stb_cnt == slv_wait + 1);
        ERR_I = slv_err_en && STB_O && (stb_cnt == slv_wait + 1);
        DAT_I = slv_use_adr ? (ADR_O ^ KEY) : slv_rdata;
        if (!CYC_O) low_run++;
        else begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end
        if (rsp_valid) begin
            rsp_cyc = cyc_n;
            total++;
            if (prev_rsp !== 1'b0) begin
                bad++;
                $display("FAIL rsp_width: rsp_valid high %0d cycles in a row, required 1", 2);
            end
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got rsp_valid, required none pending");
            end else begin
                e = sb_q.pop_front();
                if ({rsp_err, rsp_timeout, rsp_dat} !== e)
                    begin
                        bad++;
                        $display("FAIL rsp_fields: got err=%b to=%b dat=%h, required err=%b to=%b dat=%h",
                                 rsp_err, rsp_timeout, rsp_dat, e.err, e.to, e.dat);
                    end
            end
        end
        prev_rsp = rsp_valid;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input rsp_t exp);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = 4'hF;
        nxt_exp   = exp;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        total++;
        if (!accepted) begin
            bad++;
            $display("FAIL issue: command at %h not accepted, required accepted", adr);
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || !cmd_ready) && n < budget) begin
            step();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL wait_done: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) step();
        total++;
        if ({CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, rsp_valid, rsp_err, rsp_timeout, rsp_dat, cmd_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rv=%b ready=%b, required all 0",
                     CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, rsp_valid, cmd_ready);
        end
        RST = 1'b0;
        step();
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: cmd_ready=%b after reset release, required 1", cmd_ready);
        end
    endtask

    task automatic test_read();
        slv_ack_en = 1'b1; slv_err_en = 1'b0; slv_wait = 0;
        slv_use_adr = 1'b0; slv_rdata = 32'hDEAD_BEEF;
        issue(1'b0, 32'h0000_0010, 32'h0, '{err: 1'b0, to: 1'b0, dat: 32'hDEAD_BEEF});
        total++;
        if ({CYC_O, STB_O, cmd_ready} !== 3'b100) begin
            bad++;
            $display("FAIL read_c1: cyc=%b stb=%b ready=%b, required 1 0 0", CYC_O, STB_O, cmd_ready);
        end
        step();
        total++;
        if ({CYC_O, STB_O} !== 2'b11) begin
            bad++;
            $display("FAIL read_c2: cyc=%b stb=%b, required 1 1", CYC_O, STB_O);
        end
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_cyc != acc_cyc + 3 || CYC_O !== 1'b0) begin
            bad++;
            $display("FAIL read_c3: rv=%b at +%0d cyc=%b, required rv=1 at +3 cyc=0",
                     rsp_valid, rsp_cyc - acc_cyc, CYC_O);
        end
        step();
        total++;
        if ({cmd_ready, CYC_O, rsp_valid} !== 3'b100) begin
            bad++;
            $display("FAIL read_c4: ready=%b cyc=%b rv=%b, required 1 0 0", cmd_ready, CYC_O, rsp_valid);
        end
        model_dat = 32'hDEAD_BEEF;
    endtask

    task automatic test_grant_wait();
        int n = 0;
        slv_ack_en = 1'b1; slv_wait = 2;
        GNT_I = 2'd0;
        issue(1'b1, 32'h0000_0020, 32'h1234_5678, '{err: 1'b0, to: 1'b0, dat: model_dat});
        for (int i = 0; i < 6; i++) begin
            if (i == 5) GNT_I = 2'(MID);
            total++;
            if ({CYC_O, STB_O} !== 2'b10) begin
                bad++;
                $display("FAIL grant_wait_%0d: cyc=%b stb=%b, required 1 0", i, CYC_O, STB_O);
            end
            step();
        end
        total++;
        if (STB_O !== 1'b1) begin
            bad++;
            $display("FAIL grant_stb: stb=%b cycle after grant, required 1", STB_O);
        end
        while (CYC_O && n < 20) begin
            total++;
            if ({WE_O, ADR_O, DAT_O, SEL_O} !== {1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF}) begin
                bad++;
                $display("FAIL grant_bus_stable: we=%b adr=%h dat=%h sel=%h, required 1 00000020 12345678 f",
                         WE_O, ADR_O, DAT_O, SEL_O);
            end
            step();
            n++;
        end
        wait_done(20);
        slv_wait = 0;
    endtask

    task automatic test_timeout();
        int stb_high = 0;
        int n = 0;
        slv_ack_en = 1'b0;
        issue(1'b0, 32'h0000_0030, 32'h0, '{err: 1'b1, to: 1'b1, dat: model_dat});
        while (!rsp_valid && n < 30) begin
            step();
            n++;
            if (STB_O) stb_high++;
        end
        total++;
        if (!rsp_valid || CYC_O || STB_O) begin
            bad++;
            $display("FAIL timeout_end: rv=%b cyc=%b stb=%b, required 1 0 0", rsp_valid, CYC_O, STB_O);
        end
        total++;
        if (stb_high != TMO) begin
            bad++;
            $display("FAIL timeout_len: stb high %0d cycles, required %0d", stb_high, TMO);
        end
        wait_done(10);
        slv_ack_en = 1'b1;
    endtask

    task automatic test_ack_err();
        slv_ack_en = 1'b1; slv_err_en = 1'b1; slv_rdata = 32'hCAFE_F00D;
        issue(1'b0, 32'h0000_0034, 32'h0, '{err: 1'b1, to: 1'b0, dat: model_dat});
        wait_done(20);
        slv_err_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs[3] = '{32'h100, 32'h104, 32'h108};
        int n;
        slv_use_adr = 1'b1;
        cmd_we = 1'b0; cmd_dat = '0; cmd_sel = 4'hF;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_adr = addrs[k];
            nxt_exp = '{err: 1'b0, to: 1'b0, dat: addrs[k] ^ KEY};
            n = 0;
            do begin
                step();
                n++;
            end while (!accepted && n < 40);
            step();
            total++;
            if (n >= 40 || CYC_O !== 1'b1) begin
                bad++;
                $display("FAIL b2b_accept_%0d: accepted=%b cyc=%b, required 1 1", k, accepted, CYC_O);
            end
            // Low span is the GAP cycle plus the IDLE cycle that takes the next command.
            if (k > 0) begin
                total++;
                if (last_gap != 2) begin
                    bad++;
                    $display("FAIL b2b_gap_%0d: cyc low %0d cycles, required 2", k, last_gap);
                end
            end
        end
        cmd_valid = 1'b0;
        wait_done(20);
        model_dat = addrs[2] ^ KEY;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        slv_ack_en = 1'b0;
        issue(1'b0, 32'h0000_0050, 32'h0, '{err: 1'b0, to: 1'b0, dat: 32'h0});
        while (stb_cnt != 2 && n < 20) begin
            step();
            n++;
        end
        RST = 1'b1;
        sb_q.delete();
        step();
        total++;
        if ({CYC_O, STB_O, rsp_valid, cmd_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid: cyc=%b stb=%b rv=%b ready=%b, required 0 0 0 0",
                     CYC_O, STB_O, rsp_valid, cmd_ready);
        end
        step();
        RST = 1'b0;
        step();
        total++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_ready: ready=%b rv=%b, required 1 0", cmd_ready, rsp_valid);
        end
        slv_ack_en = 1'b1;
        issue(1'b0, 32'h0000_0060, 32'h0, '{err: 1'b0, to: 1'b0, dat: 32'h60 ^ KEY});
        wait_done(20);
    endtask

    initial begin
        RST = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        GNT_I = 2'(MID); DAT_I = '0; ACK_I = 1'b0; ERR_I = 1'b0;
        slv_ack_en = 1'b0; slv_err_en = 1'b0; slv_use_adr = 1'b0; slv_wait = 0; slv_rdata = '0;
        nxt_exp = '0; model_dat = '0; acc_cyc = 0; rsp_cyc = 0; stb_cnt = 0;
        low_run = 0; last_gap = 0; prev_rsp = 1'b0; accepted = 1'b0;

        test_reset();
        test_read();
        test_grant_wait();
        test_timeout();
        test_ack_err();
        test_back_to_back();
        test_reset_mid();

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
